// File: rtl/cache_memblock_burst_if.sv
// CPU access port and line burst handshakes of cache_memblock_burst.
// line_dirty exists only when CACHE_MEMBLOCK_DIRTY_EN is defined.
interface cache_memblock_burst_if #(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned LSBBITS     = 7,
  parameter int unsigned WORDLENBITS = 2
);
  logic [LSBBITS-1:0]     cpu_wraddr;
  logic [LSBBITS-1:0]     cpu_rdaddr;
  logic                   cpu_we;
  logic [DATABITS-1:0]    cpu_in;
  logic [WORDLENBITS-1:0] cpu_wordlen;
  logic                   cpu_re;
  logic [DATABITS-1:0]    cpu_out;
  logic                   cpu_out_valid;
  logic                   cpu_align_err;
  logic                   fill_start;
  logic [DATABITS-1:0]    fill_data;
  logic                   fill_valid;
  logic                   fill_ready;
  logic                   flush_start;
  logic [DATABITS-1:0]    flush_data;
  logic                   flush_valid;
  logic                   flush_ready;
  logic                   busy;
  logic                   done;
`ifdef CACHE_MEMBLOCK_DIRTY_EN
  logic                   line_dirty;

  modport slave (
    input  cpu_wraddr, cpu_rdaddr, cpu_we, cpu_in, cpu_wordlen, cpu_re,
           fill_start, fill_data, fill_valid, flush_start, flush_ready,
    output cpu_out, cpu_out_valid, cpu_align_err, fill_ready,
           flush_data, flush_valid, busy, done, line_dirty
  );
  modport master (
    output cpu_wraddr, cpu_rdaddr, cpu_we, cpu_in, cpu_wordlen, cpu_re,
           fill_start, fill_data, fill_valid, flush_start, flush_ready,
    input  cpu_out, cpu_out_valid, cpu_align_err, fill_ready,
           flush_data, flush_valid, busy, done, line_dirty
  );
`else
  modport slave (
    input  cpu_wraddr, cpu_rdaddr, cpu_we, cpu_in, cpu_wordlen, cpu_re,
           fill_start, fill_data, fill_valid, flush_start, flush_ready,
    output cpu_out, cpu_out_valid, cpu_align_err, fill_ready,
           flush_data, flush_valid, busy, done
  );
  modport master (
    output cpu_wraddr, cpu_rdaddr, cpu_we, cpu_in, cpu_wordlen, cpu_re,
           fill_start, fill_data, fill_valid, flush_start, flush_ready,
    input  cpu_out, cpu_out_valid, cpu_align_err, fill_ready,
           flush_data, flush_valid, busy, done
  );
`endif
endinterface

// File: rtl/cache_memblock_burst.sv
// Byte-banked cache line memory with CPU sub-word access and fill/flush burst engine.
// Optional dirty tracking (line_dirty) enabled by defining CACHE_MEMBLOCK_DIRTY_EN.
module cache_memblock_burst #(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned LSBBITS     = 7,
  parameter int unsigned WORDLENBITS = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  cache_memblock_burst_if.slave bus
);
  localparam int unsigned BANKNUM    = DATABITS / 8;
  localparam int unsigned LOGBANKNUM = $clog2(BANKNUM);
  localparam int unsigned IDXBITS    = LSBBITS - LOGBANKNUM;
  localparam int unsigned WORDS      = 1 << IDXBITS;
  localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH_RD, S_FLUSH_OUT} state_t;

  state_t                r_state;
  logic [IDXBITS-1:0]    r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fill_ready;
  logic                  r_flush_valid;
  logic                  r_cpu_out_valid;
  logic                  r_align_err;
  logic [LOGBANKNUM-1:0] r_rd_lane;
  logic [7:0]            r_mem  [BANKNUM][WORDS];
  logic [7:0]            r_rd_q [BANKNUM];

  logic                   w_idle;
  logic [WORDLENBITS-1:0] w_wordlen;
  logic [LOGBANKNUM-1:0]  w_wr_lane;
  logic [31:0]            w_size;
  logic                   w_cpu_wr_legal;
  logic                   w_cpu_wr;
  logic                   w_cpu_err;
  logic                   w_cpu_rd;
  logic                   w_fill_hs;
  logic                   w_flush_hs;
  logic [BANKNUM-1:0]     w_cpu_be;
  logic [BANKNUM-1:0]     w_ram_we;
  logic                   w_ram_re;
  logic [IDXBITS-1:0]     w_ram_wr_idx;
  logic [IDXBITS-1:0]     w_ram_rd_idx;
  logic [DATABITS-1:0]    w_cpu_wr_rot;
  logic [DATABITS-1:0]    w_ram_wr_data;
  logic [DATABITS-1:0]    w_rd_word;
  logic [2*DATABITS-1:0]  w_rotl;
  logic [2*DATABITS-1:0]  w_rotr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_wordlen  = bus.cpu_wordlen;
  assign w_wr_lane  = bus.cpu_wraddr[LOGBANKNUM-1:0];
  assign w_cpu_rd   = w_idle && bus.cpu_re;
  assign w_fill_hs  = (r_state == S_FILL) && r_fill_ready && bus.fill_valid;
  assign w_flush_hs = (r_state == S_FLUSH_OUT) && r_flush_valid && bus.flush_ready;

  // A size-aligned access never straddles the word, so the enable run fits the banks.
  always_comb begin
    w_size         = 32'd1 << w_wordlen;
    w_cpu_wr_legal = (w_size <= BANKNUM) && ((32'(w_wr_lane) & (w_size - 32'd1)) == 32'd0);
    for (int unsigned b = 0; b < BANKNUM; b++) begin
      w_cpu_be[b] = (b >= 32'(w_wr_lane)) && (b < 32'(w_wr_lane) + w_size);
    end
  end

  assign w_cpu_wr     = w_idle && bus.cpu_we && w_cpu_wr_legal;
  assign w_cpu_err    = w_idle && bus.cpu_we && !w_cpu_wr_legal;
  assign w_rotl       = {bus.cpu_in, bus.cpu_in} << {w_wr_lane, 3'b000};
  assign w_cpu_wr_rot = w_rotl[2*DATABITS-1:DATABITS];

  always_comb begin
    w_ram_we      = '0;
    w_ram_wr_idx  = bus.cpu_wraddr[LSBBITS-1:LOGBANKNUM];
    w_ram_wr_data = w_cpu_wr_rot;
    if (w_fill_hs) begin
      w_ram_we      = '1;
      w_ram_wr_idx  = r_cnt;
      w_ram_wr_data = bus.fill_data;
    end else if (w_cpu_wr) begin
      w_ram_we = w_cpu_be;
    end
  end

  // While a flush word stalls, the same index is re-read so the output register holds.
  always_comb begin
    w_ram_re     = 1'b0;
    w_ram_rd_idx = bus.cpu_rdaddr[LSBBITS-1:LOGBANKNUM];
    case (r_state)
      S_IDLE:      w_ram_re = bus.cpu_re;
      S_FLUSH_RD: begin
        w_ram_re     = 1'b1;
        w_ram_rd_idx = r_cnt;
      end
      S_FLUSH_OUT: begin
        w_ram_re     = 1'b1;
        w_ram_rd_idx = w_flush_hs ? r_cnt + IDXBITS'(1) : r_cnt;
      end
      default:     w_ram_re = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BANKNUM; b++) begin
      if (w_ram_we[b]) r_mem[b][w_ram_wr_idx] <= w_ram_wr_data[b*8 +: 8];
      if (w_ram_re)    r_rd_q[b] <= r_mem[b][w_ram_rd_idx];
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int unsigned b = 0; b < BANKNUM; b++) begin
      w_rd_word[b*8 +: 8] = r_rd_q[b];
    end
  end

  assign w_rotr = {w_rd_word, w_rd_word} >> {r_rd_lane, 3'b000};

`ifdef CACHE_MEMBLOCK_DIRTY_EN
  logic r_dirty;
  assign bus.line_dirty = r_dirty;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_fill_ready    <= 1'b0;
      r_flush_valid   <= 1'b0;
      r_cpu_out_valid <= 1'b0;
      r_align_err     <= 1'b0;
      r_rd_lane       <= '0;
`ifdef CACHE_MEMBLOCK_DIRTY_EN
      r_dirty         <= 1'b0;
`endif
    end else begin
      r_done          <= 1'b0;
      r_cpu_out_valid <= w_cpu_rd;
      r_align_err     <= w_cpu_err;
      if (w_cpu_rd) r_rd_lane <= bus.cpu_rdaddr[LOGBANKNUM-1:0];
`ifdef CACHE_MEMBLOCK_DIRTY_EN
      if (w_cpu_wr) r_dirty <= 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.fill_start) begin
            r_state      <= S_FILL;
            r_busy       <= 1'b1;
            r_fill_ready <= 1'b1;
          end else if (bus.flush_start) begin
            r_state <= S_FLUSH_RD;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_fill_hs) begin
            if (r_cnt == LAST_IDX) begin
              r_state      <= S_IDLE;
              r_cnt        <= '0;
              r_busy       <= 1'b0;
              r_fill_ready <= 1'b0;
              r_done       <= 1'b1;
`ifdef CACHE_MEMBLOCK_DIRTY_EN
              r_dirty      <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + IDXBITS'(1);
            end
          end
        end
        S_FLUSH_RD: begin
          r_state       <= S_FLUSH_OUT;
          r_flush_valid <= 1'b1;
        end
        S_FLUSH_OUT: begin
          if (w_flush_hs) begin
            if (r_cnt == LAST_IDX) begin
              r_state       <= S_IDLE;
              r_cnt         <= '0;
              r_busy        <= 1'b0;
              r_flush_valid <= 1'b0;
              r_done        <= 1'b1;
`ifdef CACHE_MEMBLOCK_DIRTY_EN
              r_dirty       <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + IDXBITS'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_out       = r_cpu_out_valid ? w_rotr[DATABITS-1:0] : '0;
  assign bus.cpu_out_valid = r_cpu_out_valid;
  assign bus.cpu_align_err = r_align_err;
  assign bus.fill_ready    = r_fill_ready;
  assign bus.flush_data    = r_flush_valid ? w_rd_word : '0;
  assign bus.flush_valid   = r_flush_valid;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_cache_memblock_burst.sv
// Scoreboard bench for cache_memblock_burst: 32-bit/128-byte and 64-bit/256-byte instances.
module tb_cache_memblock_burst;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_memblock_burst_if #(.DATABITS(32), .LSBBITS(7), .WORDLENBITS(2)) if0 ();
  cache_memblock_burst_if #(.DATABITS(64), .LSBBITS(8), .WORDLENBITS(2)) if1 ();

  cache_memblock_burst #(.DATABITS(32), .LSBBITS(7), .WORDLENBITS(2)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  cache_memblock_burst #(.DATABITS(64), .LSBBITS(8), .WORDLENBITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  m0 [128];
  logic [7:0]  m1 [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.cpu_wraddr = '0; if0.cpu_rdaddr = '0; if0.cpu_we = 1'b0; if0.cpu_in = '0;
    if0.cpu_wordlen = '0; if0.cpu_re = 1'b0; if0.fill_start = 1'b0; if0.fill_data = '0;
    if0.fill_valid = 1'b0; if0.flush_start = 1'b0; if0.flush_ready = 1'b0;
    if1.cpu_wraddr = '0; if1.cpu_rdaddr = '0; if1.cpu_we = 1'b0; if1.cpu_in = '0;
    if1.cpu_wordlen = '0; if1.cpu_re = 1'b0; if1.fill_start = 1'b0; if1.fill_data = '0;
    if1.fill_valid = 1'b0; if1.flush_start = 1'b0; if1.flush_ready = 1'b0;
  endtask

  // Byte-level reference: a read returns the bytes of the word starting at the lane, wrapping.
  function automatic logic [31:0] m0_read(int addr);
    logic [31:0] r;
    int base = (addr / 4) * 4;
    int lane = addr % 4;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m0[base + (k + lane) % 4];
    return r;
  endfunction

  function automatic logic m0_write(int addr, int wl, logic [31:0] d);
    int size = 1 << wl;
    if (size > 4 || (addr % size) != 0) return 1'b0;
    for (int k = 0; k < size; k++) m0[addr + k] = d[k*8 +: 8];
    return 1'b1;
  endfunction

  function automatic logic [63:0] m1_read(int addr);
    logic [63:0] r;
    int base = (addr / 8) * 8;
    int lane = addr % 8;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = m1[base + (k + lane) % 8];
    return r;
  endfunction

  function automatic logic m1_write(int addr, int wl, logic [63:0] d);
    int size = 1 << wl;
    if (size > 8 || (addr % size) != 0) return 1'b0;
    for (int k = 0; k < size; k++) m1[addr + k] = d[k*8 +: 8];
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({if0.busy, if0.done, if0.fill_ready, if0.flush_valid, if0.cpu_out_valid, if0.cpu_align_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl0: got %b expected 000000",
        {if0.busy, if0.done, if0.fill_ready, if0.flush_valid, if0.cpu_out_valid, if0.cpu_align_err});
    end
    checks++;
    if (if0.cpu_out !== 32'h0 || if0.flush_data !== 32'h0) begin
      errors++; $display("FAIL reset_data0: cpu_out %h flush_data %h expected 0", if0.cpu_out, if0.flush_data);
    end
    checks++;
    if ({if1.busy, if1.done, if1.fill_ready, if1.flush_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl1: got %b expected 0000", {if1.busy, if1.done, if1.fill_ready, if1.flush_valid});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int got = 0, cyc = 0, done_cnt = 0, got_at_done = -1;
    logic acc;
    if0.fill_start = 1'b1;
    tick();
    if0.fill_start = 1'b0;
    checks++;
    if ({if0.busy, if0.fill_ready} !== 2'b11) begin
      errors++; $display("FAIL fill_enter: busy/fill_ready %b expected 11", {if0.busy, if0.fill_ready});
    end
    while (got < 32 && cyc < 200) begin
      if0.fill_valid = (cyc % 3) != 2;
      if0.fill_data  = 32'h100 + 32'(got);
      acc = if0.fill_valid && if0.fill_ready;
      if (acc) for (int k = 0; k < 4; k++) m0[got*4 + k] = if0.fill_data[k*8 +: 8];
      tick();
      cyc++;
      if (acc) got++;
      if (if0.done) begin done_cnt++; got_at_done = got; end
    end
    if0.fill_valid = 1'b0;
    checks++;
    if (got != 32) begin errors++; $display("FAIL fill_count: got %0d words expected 32", got); end
    checks++;
    if (done_cnt != 1 || got_at_done != 32) begin
      errors++; $display("FAIL fill_done: %0d pulses at word %0d expected 1 at 32", done_cnt, got_at_done);
    end
    tick();
    checks++;
    if ({if0.busy, if0.done, if0.fill_ready} !== 3'b000) begin
      errors++; $display("FAIL fill_exit: busy/done/ready %b expected 000", {if0.busy, if0.done, if0.fill_ready});
    end
  endtask

  task automatic test_cpu_access();
    int wa[5] = '{4, 5, 3, 0, 8};
    int ww[5] = '{2, 0, 1, 3, 2};
    logic [31:0] wd[5] = '{32'h0, 32'hAB, 32'h1234, 32'h55, 32'hDEADBEEF};
    int extra[5] = '{5, 3, 10, 13, 6};
    logic legal;
    logic [63:0] e;
    for (int i = 0; i < 5; i++) begin
      legal = m0_write(wa[i], ww[i], wd[i]);
      if0.cpu_we = 1'b1; if0.cpu_wraddr = 7'(wa[i]); if0.cpu_wordlen = 2'(ww[i]); if0.cpu_in = wd[i];
      tick();
      if0.cpu_we = 1'b0;
      checks++;
      if (if0.cpu_align_err !== !legal) begin
        errors++; $display("FAIL align_err: addr %h len %0d got %b expected %b", wa[i], ww[i], if0.cpu_align_err, !legal);
      end
      tick();
      checks++;
      if (if0.cpu_align_err !== 1'b0) begin
        errors++; $display("FAIL align_pulse: addr %h got %b expected 0", wa[i], if0.cpu_align_err);
      end
    end
    // read and write of the same word in one cycle: old contents come back
    exp_q.push_back(64'(m0_read(16)));
    legal = m0_write(16, 2, 32'hCAFEF00D);
    if0.cpu_we = 1'b1; if0.cpu_wraddr = 7'd16; if0.cpu_wordlen = 2'd2; if0.cpu_in = 32'hCAFEF00D;
    if0.cpu_re = 1'b1; if0.cpu_rdaddr = 7'd16;
    tick();
    if0.cpu_we = 1'b0; if0.cpu_re = 1'b0;
    checks++;
    if (!if0.cpu_out_valid || exp_q.size() == 0) begin
      errors++; $display("FAIL rdw_valid: valid %b expected 1", if0.cpu_out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (if0.cpu_out !== e[31:0]) begin errors++; $display("FAIL rdw_old: got %h expected %h", if0.cpu_out, e[31:0]); end
    end
    for (int i = 0; i < 37; i++) begin
      int a;
      a = (i < 32) ? 4 * i : extra[i - 32];
      if0.cpu_re = 1'b1; if0.cpu_rdaddr = 7'(a);
      exp_q.push_back(64'(m0_read(a)));
      tick();
      checks++;
      if (!if0.cpu_out_valid || exp_q.size() == 0) begin
        errors++; $display("FAIL rd_valid: addr %h valid %b expected 1", a, if0.cpu_out_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (if0.cpu_out !== e[31:0]) begin errors++; $display("FAIL rd_data: addr %h got %h expected %h", a, if0.cpu_out, e[31:0]); end
      end
    end
    if0.cpu_re = 1'b0;
    tick();
    checks++;
    if (if0.cpu_out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL rd_idle: valid %b pending %0d expected 0/0", if0.cpu_out_valid, exp_q.size());
    end
  endtask

  task automatic test_flush();
    int got = 0, cyc = 0, done_cnt = 0;
    logic stalled = 1'b0, tog = 1'b1;
    logic [31:0] held = '0;
    logic [63:0] e;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(64'(m0_read(4 * i)));
    if0.flush_start = 1'b1;
    tick();
    if0.flush_start = 1'b0;
    checks++;
    if ({if0.busy, if0.flush_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_rd: busy/valid %b expected 10", {if0.busy, if0.flush_valid});
    end
    while (got < 32 && cyc < 300) begin
      if (stalled) begin
        checks++;
        if (if0.flush_valid !== 1'b1 || if0.flush_data !== held) begin
          errors++; $display("FAIL flush_hold: valid %b data %h expected 1 %h", if0.flush_valid, if0.flush_data, held);
        end
      end
      if0.flush_ready = tog;
      tog = !tog;
      stalled = 1'b0;
      if (if0.flush_valid) begin
        if (if0.flush_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL flush_extra: word %h expected none", if0.flush_data);
          end else begin
            e = exp_q.pop_front();
            if (if0.flush_data !== e[31:0]) begin
              errors++; $display("FAIL flush_data: word %0d got %h expected %h", got, if0.flush_data, e[31:0]);
            end
          end
          got++;
        end else begin
          held = if0.flush_data;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
      if (if0.done) done_cnt++;
    end
    if0.flush_ready = 1'b0;
    repeat (3) begin tick(); if (if0.done) done_cnt++; end
    checks++;
    if (got != 32 || exp_q.size() != 0) begin errors++; $display("FAIL flush_count: got %0d expected 32", got); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL flush_done: %0d pulses expected 1", done_cnt); end
    checks++;
    if ({if0.busy, if0.flush_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_exit: busy/valid %b expected 00", {if0.busy, if0.flush_valid});
    end
  endtask

  task automatic test_fill_priority_abort();
    int done_cnt = 0;
    logic [63:0] e;
    if0.fill_start = 1'b1; if0.flush_start = 1'b1;
    tick();
    if0.fill_start = 1'b0; if0.flush_start = 1'b0;
    tick();
    checks++;
    if ({if0.busy, if0.fill_ready, if0.flush_valid} !== 3'b110) begin
      errors++; $display("FAIL start_prio: busy/fill_ready/flush_valid %b expected 110",
        {if0.busy, if0.fill_ready, if0.flush_valid});
    end
    for (int i = 0; i <= 10; i++) begin
      if0.fill_valid = 1'b1;
      if0.fill_data  = 32'h200 + 32'(i);
      for (int k = 0; k < 4; k++) m0[i*4 + k] = if0.fill_data[k*8 +: 8];
      tick();
      if (if0.done) done_cnt++;
    end
    if0.fill_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if0.busy, if0.fill_ready, if0.done} !== 3'b000) begin
      errors++; $display("FAIL abort_reset: busy/ready/done %b expected 000", {if0.busy, if0.fill_ready, if0.done});
    end
    tick();
    reset_n = 1'b1;
    repeat (4) begin tick(); if (if0.done) done_cnt++; end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: %0d pulses expected 0", done_cnt); end
    for (int i = 0; i < 2; i++) begin
      int a;
      a = 40 + 4 * i;
      if0.cpu_re = 1'b1; if0.cpu_rdaddr = 7'(a);
      exp_q.push_back(64'(m0_read(a)));
      tick();
      checks++;
      if (!if0.cpu_out_valid || exp_q.size() == 0) begin
        errors++; $display("FAIL abort_rd_valid: addr %h valid %b expected 1", a, if0.cpu_out_valid);
      end else begin
        e = exp_q.pop_front();
        if (if0.cpu_out !== e[31:0]) begin errors++; $display("FAIL abort_rd: addr %h got %h expected %h", a, if0.cpu_out, e[31:0]); end
      end
    end
    if0.cpu_re = 1'b0;
    tick();
  endtask

  task automatic test_wide();
    int got = 0, cyc = 0, done_cnt = 0, gaps = 0;
    int ra[3] = '{8, 12, 0};
    logic legal;
    logic [63:0] e;
    if1.fill_start = 1'b1;
    tick();
    if1.fill_start = 1'b0;
    while (got < 32 && cyc < 100) begin
      if1.fill_valid = 1'b1;
      if1.fill_data  = {32'hA5000000 + 32'(got), 32'h5A000000 + 32'(got)};
      if (if1.fill_ready) begin
        for (int k = 0; k < 8; k++) m1[got*8 + k] = if1.fill_data[k*8 +: 8];
        got++;
      end
      tick();
      cyc++;
      if (if1.done) done_cnt++;
    end
    if1.fill_valid = 1'b0;
    tick();
    checks++;
    if (got != 32 || done_cnt != 1 || if1.busy !== 1'b0) begin
      errors++; $display("FAIL w_fill: words %0d done %0d busy %b expected 32 1 0", got, done_cnt, if1.busy);
    end
    for (int i = 0; i < 2; i++) begin
      int a;
      a = (i == 0) ? 8 : 4;
      legal = m1_write(a, 3, 64'h1122334455667788);
      if1.cpu_we = 1'b1; if1.cpu_wraddr = 8'(a); if1.cpu_wordlen = 2'd3; if1.cpu_in = 64'h1122334455667788;
      tick();
      if1.cpu_we = 1'b0;
      checks++;
      if (if1.cpu_align_err !== !legal) begin
        errors++; $display("FAIL w_align: addr %h got %b expected %b", a, if1.cpu_align_err, !legal);
      end
`ifdef CACHE_MEMBLOCK_DIRTY_EN
      checks++;
      if (if1.line_dirty !== 1'b1) begin errors++; $display("FAIL w_dirty_set: got %b expected 1", if1.line_dirty); end
`endif
    end
    for (int i = 0; i < 3; i++) begin
      if1.cpu_re = 1'b1; if1.cpu_rdaddr = 8'(ra[i]);
      exp_q.push_back(m1_read(ra[i]));
      tick();
      checks++;
      if (!if1.cpu_out_valid || exp_q.size() == 0) begin
        errors++; $display("FAIL w_rd_valid: addr %h valid %b expected 1", ra[i], if1.cpu_out_valid);
      end else begin
        e = exp_q.pop_front();
        if (if1.cpu_out !== e) begin errors++; $display("FAIL w_rd: addr %h got %h expected %h", ra[i], if1.cpu_out, e); end
      end
    end
    if1.cpu_re = 1'b0;
    for (int i = 0; i < 32; i++) exp_q.push_back(m1_read(8 * i));
    got = 0; cyc = 0; done_cnt = 0;
    if1.flush_start = 1'b1;
    tick();
    if1.flush_start = 1'b0;
    if1.flush_ready = 1'b1;
    while (got < 32 && cyc < 100) begin
      if (if1.flush_valid) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h0;
        if (if1.flush_data !== e) begin
          errors++; $display("FAIL w_flush_data: word %0d got %h expected %h", got, if1.flush_data, e);
        end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      tick();
      cyc++;
      if (if1.done) done_cnt++;
    end
    if1.flush_ready = 1'b0;
    checks++;
    if (got != 32 || gaps != 0 || done_cnt != 1) begin
      errors++; $display("FAIL w_flush: words %0d bubbles %0d done %0d expected 32 0 1", got, gaps, done_cnt);
    end
`ifdef CACHE_MEMBLOCK_DIRTY_EN
    checks++;
    if (if1.line_dirty !== 1'b0) begin errors++; $display("FAIL w_dirty_clr: got %b expected 0", if1.line_dirty); end
`endif
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_cpu_access();
    test_flush();
    test_fill_priority_abort();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
